// File: rtl/paddle_motion.sv
// rtl/paddle_motion.sv - paddle x-position with acceleration, friction and wall clamping
module paddle_motion #(
  parameter int unsigned X_MIN    = 5,
  parameter int unsigned X_MAX    = 540,
  parameter int unsigned X_INIT   = 200,
  parameter int unsigned ACCEL    = 2,
  parameter int unsigned VMAX     = 12,
  parameter int unsigned FRICTION = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       recenter,
  input  logic       key_left,
  input  logic       key_right,
  output logic [9:0] board_x,
  output logic [4:0] speed,
  output logic       dir,
  output logic       moving,
  output logic       wall_hit
);

  typedef enum logic [1:0] {IDLE, RIGHT, LEFT} state_t;

  localparam logic [10:0] XMIN_W  = 11'(X_MIN);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [9:0]  XINIT_W = 10'(X_INIT);
  localparam logic [5:0]  ACCEL_W = 6'(ACCEL);
  localparam logic [5:0]  VMAX_W  = 6'(VMAX);
  localparam logic [5:0]  FRIC_W  = 6'(FRICTION);

  state_t      state_q, state_d;
  logic [9:0]  x_d;
  logic [4:0]  speed_d;
  logic        dir_d;
  logic        hit_d;
  logic [4:0]  spd_new;
  logic [5:0]  acc_sum;
  logic [10:0] pos_sum;
  logic [10:0] lo_lim;
  logic        cmd_right;
  logic        cmd_left;

  assign cmd_right = key_right & ~key_left;
  assign cmd_left  = key_left & ~key_right;

  // state, speed and position registers; moving is decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      board_x  <= XINIT_W;
      speed    <= 5'd0;
      dir      <= 1'b1;
      moving   <= 1'b0;
      wall_hit <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_x  <= x_d;
      speed    <= speed_d;
      dir      <= dir_d;
      moving   <= (state_d != IDLE);
      wall_hit <= hit_d;
    end
  end

  // next-state: control priority, speed ramp, then position with wall clamp using the new speed
  always_comb begin
    state_d = state_q;
    x_d     = board_x;
    speed_d = speed;
    dir_d   = dir;
    hit_d   = 1'b0;
    spd_new = speed;
    acc_sum = {1'b0, speed} + ACCEL_W;
    pos_sum = 11'd0;
    lo_lim  = 11'd0;

    if (recenter) begin
      x_d     = XINIT_W;
      speed_d = 5'd0;
      state_d = IDLE;
    end else if (!enable) begin
      speed_d = 5'd0;
      state_d = IDLE;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (cmd_right) begin
            state_d = RIGHT;
            dir_d   = 1'b1;
            spd_new = ACCEL_W[4:0];
          end else if (cmd_left) begin
            state_d = LEFT;
            dir_d   = 1'b0;
            spd_new = ACCEL_W[4:0];
          end
        end
        RIGHT, LEFT: begin
          // only a key in the current direction accelerates; anything else brakes
          if ((state_q == RIGHT && cmd_right) || (state_q == LEFT && cmd_left)) begin
            spd_new = (acc_sum > VMAX_W) ? VMAX_W[4:0] : acc_sum[4:0];
          end else begin
            spd_new = ({1'b0, speed} > FRIC_W) ? (speed - FRIC_W[4:0]) : 5'd0;
          end
          if (spd_new == 5'd0) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      speed_d = spd_new;
      pos_sum = {1'b0, board_x} + {6'b0, spd_new};
      lo_lim  = XMIN_W + {6'b0, spd_new};

      if (state_d == RIGHT) begin
        if ({1'b0, board_x} >= XMAX_W) begin
          // already against the wall: refuse the move silently
          speed_d = 5'd0;
          state_d = IDLE;
        end else if (pos_sum >= XMAX_W) begin
          x_d     = XMAX_W[9:0];
          speed_d = 5'd0;
          state_d = IDLE;
          hit_d   = 1'b1;
        end else begin
          x_d = pos_sum[9:0];
        end
      end else if (state_d == LEFT) begin
        if ({1'b0, board_x} <= XMIN_W) begin
          speed_d = 5'd0;
          state_d = IDLE;
        end else if ({1'b0, board_x} <= lo_lim) begin
          x_d     = XMIN_W[9:0];
          speed_d = 5'd0;
          state_d = IDLE;
          hit_d   = 1'b1;
        end else begin
          x_d = board_x - {5'b0, spd_new};
        end
      end
    end
  end

endmodule
